// File: rtl/cbus_arbiter_if.sv
// -----------------------------------------------------------------------------
// cbus_pkg / cbus_arbiter_if
//   Cache-bus (cbus) request/response types and the bundle that carries the
//   arbiter's bus-side signals.
//
//   cbus_req_t  : valid, is_write, addr, size, len (beats-1), data, strobe
//   cbus_resp_t : ready, last, data
//
//   Interface signals:
//     ireqs  [NUM_MASTERS] cbus_req_t   per-master requests      (master -> arb)
//     iresps [NUM_MASTERS] cbus_resp_t  per-master responses     (arb -> master)
//     oreq                 cbus_req_t   request to downstream    (arb -> bridge)
//     oresp                cbus_resp_t  response from downstream (bridge -> arb)
//     busy                 1            a transaction is owned
//     owner                IDX_W        index of current owner
//
//   Modports: slave = arbiter view, master = view of the surrounding system.
// -----------------------------------------------------------------------------
package cbus_pkg;

    // Burst length, encoded as beats-1.
    localparam logic [3:0] MLEN1  = 4'd0;
    localparam logic [3:0] MLEN2  = 4'd1;
    localparam logic [3:0] MLEN4  = 4'd3;
    localparam logic [3:0] MLEN8  = 4'd7;
    localparam logic [3:0] MLEN16 = 4'd15;

    typedef struct packed {
        logic        valid;
        logic        is_write;
        logic [31:0] addr;
        logic [2:0]  size;
        logic [3:0]  len;
        logic [63:0] data;
        logic [7:0]  strobe;
    } cbus_req_t;

    typedef struct packed {
        logic        ready;
        logic        last;
        logic [63:0] data;
    } cbus_resp_t;

endpackage

interface cbus_arbiter_if #(
    parameter int NUM_MASTERS = 2
);
    import cbus_pkg::*;

    localparam int IDX_W = $clog2(NUM_MASTERS);

    cbus_req_t  [NUM_MASTERS-1:0] ireqs;
    cbus_resp_t [NUM_MASTERS-1:0] iresps;
    cbus_req_t                    oreq;
    cbus_resp_t                   oresp;
    logic                         busy;
    logic       [IDX_W-1:0]       owner;

    modport slave (
        input  ireqs,
        input  oresp,
        output iresps,
        output oreq,
        output busy,
        output owner
    );

    modport master (
        output ireqs,
        output oresp,
        input  iresps,
        input  oreq,
        input  busy,
        input  owner
    );

endinterface

// File: rtl/cbus_arbiter.sv
// -----------------------------------------------------------------------------
// cbus_arbiter
//   Shares one downstream cbus port between NUM_MASTERS cache masters.
//   One master owns the bus per transaction; the grant is held until the
//   owner's final beat (oresp.ready && oresp.last) or until the owner drops
//   valid. Arbitration costs one IDLE cycle, so consecutive transactions are
//   always separated by a cycle with oreq.valid=0.
//
//   Ports:
//     clk    core clock
//     reset  synchronous, active-high reset
//     bus    cbus_arbiter_if.slave (ireqs/iresps/oreq/oresp/busy/owner)
//
//   Build option:
//     CBUS_ARBITER_RR_EN  defined   -> round-robin arbitration (prio_q kept)
//                         undefined -> fixed priority, lowest index wins
// -----------------------------------------------------------------------------

// Per-master response gate: a master sees the downstream response only while
// it is the selected owner, otherwise all zeros.
module cbus_arb_lane
    import cbus_pkg::*;
(
    input  logic       i_sel,
    input  cbus_resp_t i_oresp,
    output cbus_resp_t o_iresp
);
    assign o_iresp = i_sel ? i_oresp : '0;
endmodule

module cbus_arbiter
    import cbus_pkg::*;
#(
    parameter  int NUM_MASTERS = 2,
    localparam int IDX_W       = $clog2(NUM_MASTERS)
) (
    input  logic           clk,
    input  logic           reset,
    cbus_arbiter_if.slave  bus
);

    typedef enum logic {
        S_IDLE = 1'b0,
        S_BUSY = 1'b1
    } state_t;

    state_t                       r_state;
    state_t                       w_state_nxt;
    logic       [IDX_W-1:0]       r_owner;
    logic       [IDX_W-1:0]       w_owner_nxt;
    logic       [IDX_W-1:0]       w_winner;
    logic                         w_any;
    logic                         w_done;
    logic       [IDX_W-1:0]       w_owner_inc;
    cbus_req_t                    w_own_req;
    logic       [NUM_MASTERS-1:0] w_sel;
    cbus_resp_t [NUM_MASTERS-1:0] w_iresps;

    assign w_own_req   = bus.ireqs[r_owner];
    assign w_owner_inc = (r_owner == IDX_W'(NUM_MASTERS-1)) ? '0 : r_owner + 1'b1;

`ifdef CBUS_ARBITER_RR_EN
    logic [IDX_W-1:0] r_prio;

    // Scan from r_prio upward, wrapping; first valid master wins.
    always_comb begin
        int idx;
        w_any    = 1'b0;
        w_winner = '0;
        idx      = 0;
        for (int k = 0; k < NUM_MASTERS; k++) begin
            idx = int'(r_prio) + k;
            if (idx >= NUM_MASTERS) idx = idx - NUM_MASTERS;
            if (!w_any && bus.ireqs[IDX_W'(idx)].valid) begin
                w_any    = 1'b1;
                w_winner = IDX_W'(idx);
            end
        end
    end

    // Rotate priority past the master that just finished or abandoned.
    always_ff @(posedge clk) begin
        if (reset)
            r_prio <= '0;
        else if (w_done)
            r_prio <= w_owner_inc;
    end
`else
    // Fixed priority: walk down so the lowest valid index is the last write.
    always_comb begin
        w_any    = 1'b0;
        w_winner = '0;
        for (int k = NUM_MASTERS-1; k >= 0; k--) begin
            if (bus.ireqs[IDX_W'(k)].valid) begin
                w_any    = 1'b1;
                w_winner = IDX_W'(k);
            end
        end
    end
`endif

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
            r_owner <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_owner <= w_owner_nxt;
        end
    end

    // Next-state logic. An owner dropping valid mid-burst ends the transaction
    // the same way a last beat does.
    always_comb begin
        w_state_nxt = r_state;
        w_owner_nxt = r_owner;
        w_done      = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_any) begin
                    w_state_nxt = S_BUSY;
                    w_owner_nxt = w_winner;
                end
            end
            S_BUSY: begin
                if ((bus.oresp.ready && bus.oresp.last) || !w_own_req.valid) begin
                    w_state_nxt = S_IDLE;
                    w_done      = 1'b1;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Outputs. oreq depends only on state and ireqs, never on oresp, and
    // spurious responses in IDLE are dropped because no lane is selected.
    always_comb begin
        bus.oreq  = '0;
        w_sel     = '0;
        bus.busy  = 1'b0;
        bus.owner = r_owner;
        if (r_state == S_BUSY) begin
            bus.oreq         = w_own_req;
            w_sel[r_owner]   = 1'b1;
            bus.busy         = 1'b1;
        end
    end

    for (genvar g = 0; g < NUM_MASTERS; g++) begin : g_lane
        cbus_arb_lane u_lane (
            .i_sel   (w_sel[g]),
            .i_oresp (bus.oresp),
            .o_iresp (w_iresps[g])
        );
    end

    assign bus.iresps = w_iresps;

endmodule

// File: tb/tb_cbus_arbiter.sv
`timescale 1ns/1ps
module tb_cbus_arbiter;
    import cbus_pkg::*;

    localparam int N  = 3;
    localparam int IW = $clog2(N);

    logic clk   = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    cbus_arbiter_if #(.NUM_MASTERS(N)) bus();

    cbus_arbiter #(.NUM_MASTERS(N)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    int n_tot  = 0;
    int n_fail = 0;

`ifdef CBUS_ARBITER_RR_EN
    localparam bit RR = 1'b1;
`else
    localparam bit RR = 1'b0;
`endif

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_tot++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic cbus_req_t req_at(input int i);
        return bus.ireqs[IW'(i)];
    endfunction

    function automatic cbus_resp_t resp_at(input int i);
        return bus.iresps[IW'(i)];
    endfunction

    task automatic set_req(input int i, input cbus_req_t r);
        bus.ireqs[IW'(i)] = r;
    endtask

    task automatic set_valid(input int i, input logic v);
        bus.ireqs[IW'(i)].valid = v;
    endtask

    function automatic cbus_req_t mk_req(input logic v, input logic wr, input logic [31:0] a,
                                         input logic [3:0] len);
        cbus_req_t r;
        r          = '0;
        r.valid    = v;
        r.is_write = wr;
        r.addr     = a;
        r.size     = 3'd3;
        r.len      = len;
        r.strobe   = wr ? 8'hff : 8'h00;
        return r;
    endfunction

    function automatic cbus_resp_t mk_resp(input logic rdy, input logic lst, input logic [63:0] d);
        cbus_resp_t r;
        r.ready = rdy;
        r.last  = lst;
        r.data  = d;
        return r;
    endfunction

    task automatic clear_inputs();
        bus.ireqs = '0;
        bus.oresp = '0;
    endtask

    task automatic do_reset();
        clear_inputs();
        reset = 1'b1;
        step();
        step();
        reset = 1'b0;
    endtask

    // Reference model: the bus is either free or owned by one master index.
    bit m_busy;
    int m_own;
    int m_prio;

    function automatic int pick(input logic [N-1:0] v, input int start);
        logic [N-1:0] vv;
        for (int k = 0; k < N; k++) begin
            vv = v >> ((start + k) % N);
            if (vv[0]) return (start + k) % N;
        end
        return -1;
    endfunction

    typedef struct {
        logic [N-1:0] v;
        logic         rdy;
        logic         last;
        logic         exp_busy;
        int           exp_own;
        int           exp_src;    // master whose request appears on oreq, -1 = zero
        int           exp_route;  // master receiving oresp, -1 = nobody
    } tv_t;

    tv_t tv [12];

    initial begin
        cbus_req_t     r;
        logic [N-1:0]  vv;
        int            w;

        // Fixed master payloads used by the vector table.
        tv[0]  = '{3'b011, 1'b0, 1'b0, 1'b0, 0, -1, -1};
        tv[1]  = '{3'b011, 1'b1, 1'b0, 1'b1, 0,  0,  0};
        tv[2]  = '{3'b011, 1'b1, 1'b1, 1'b1, 0,  0,  0};
        tv[3]  = '{3'b010, 1'b1, 1'b1, 1'b0, 0, -1, -1};
        tv[4]  = '{3'b010, 1'b0, 1'b0, 1'b1, 1,  1,  1};
        tv[5]  = '{3'b011, 1'b1, 1'b1, 1'b1, 1,  1,  1};
        tv[6]  = '{3'b001, 1'b0, 1'b0, 1'b0, 1, -1, -1};
        tv[7]  = '{3'b001, 1'b1, 1'b0, 1'b1, 0,  0,  0};
        tv[8]  = '{3'b000, 1'b1, 1'b0, 1'b1, 0,  0,  0};
        tv[9]  = '{3'b100, 1'b0, 1'b0, 1'b0, 0, -1, -1};
        tv[10] = '{3'b100, 1'b1, 1'b1, 1'b1, 2,  2,  2};
        tv[11] = '{3'b000, 1'b0, 1'b0, 1'b0, 2, -1, -1};

        // Reset state
        do_reset();
        reset = 1'b1;
        #1;
        chk("rst_busy", bus.busy, 0);
        chk("rst_owner", bus.owner, 0);
        chk("rst_oreq", bus.oreq, '0);
        for (int i = 0; i < N; i++) chk("rst_iresp", resp_at(i), '0);
        step();
        reset = 1'b0;

        // Vector table
        for (int t = 0; t < 12; t++) begin
            for (int i = 0; i < N; i++) begin
                r       = mk_req(1'b0, 1'b0, 32'h1000_0000 + 32'(i) * 32'h100, MLEN2);
                r.data  = 64'hA0 + 64'(i);
                r.valid = tv[t].v[i];
                set_req(i, r);
            end
            bus.oresp = mk_resp(tv[t].rdy, tv[t].last, 64'hD000 + 64'(t));
            #1;
            chk("tv_busy", bus.busy, tv[t].exp_busy);
            chk("tv_owner", bus.owner, tv[t].exp_own);
            chk("tv_oreq", bus.oreq, (tv[t].exp_src < 0) ? '0 : req_at(tv[t].exp_src));
            for (int i = 0; i < N; i++)
                chk("tv_iresp", resp_at(i), (i == tv[t].exp_route) ? bus.oresp : '0);
            step();
        end

        // Single master, 16-beat read
        do_reset();
        set_req(1, mk_req(1'b1, 1'b0, 32'h8000_0000, MLEN16));
        #1;
        chk("sm_idle_valid", bus.oreq.valid, 0);
        step();
        chk("sm_grant_valid", bus.oreq.valid, 1);
        chk("sm_grant_addr", bus.oreq.addr, 32'h8000_0000);
        chk("sm_grant_owner", bus.owner, 1);
        for (int b = 0; b < 16; b++) begin
            bus.oresp = mk_resp(1'b1, b == 15, 64'h100 + 64'(b));
            #1;
            chk("sm_beat_m1", resp_at(1), mk_resp(1'b1, b == 15, 64'h100 + 64'(b)));
            chk("sm_beat_m0", resp_at(0), '0);
            step();
        end
        clear_inputs();
        #1;
        chk("sm_done_busy", bus.busy, 0);
        chk("sm_done_valid", bus.oreq.valid, 0);

        // Write pass-through, 4 beats
        do_reset();
        r      = mk_req(1'b1, 1'b1, 32'h2000_0040, MLEN4);
        r.data = 64'h11;
        set_req(0, r);
        step();
        for (int k = 0; k < 4; k++) begin
            r.data = 64'h11 * 64'(k + 1);
            set_req(0, r);
            bus.oresp = mk_resp(1'b1, k == 3, '0);
            #1;
            chk("wr_busy", bus.busy, 1);
            chk("wr_data", bus.oreq.data, 64'h11 * 64'(k + 1));
            chk("wr_strobe", bus.oreq.strobe, 8'hff);
            step();
        end
        clear_inputs();
        #1;
        chk("wr_done_busy", bus.busy, 0);

        // Abandon after 2 of 8 beats, master 1 pending
        do_reset();
        set_req(0, mk_req(1'b1, 1'b0, 32'h3000_0000, MLEN8));
        set_req(1, mk_req(1'b1, 1'b0, 32'h3100_0000, MLEN1));
        step();
        for (int k = 0; k < 2; k++) begin
            bus.oresp = mk_resp(1'b1, 1'b0, 64'(k));
            #1;
            chk("ab_owner0", bus.owner, 0);
            step();
        end
        set_valid(0, 1'b0);
        bus.oresp = '0;
        #1;
        chk("ab_drop_busy", bus.busy, 1);
        chk("ab_drop_valid", bus.oreq.valid, 0);
        step();
        chk("ab_idle_busy", bus.busy, 0);
        chk("ab_idle_valid", bus.oreq.valid, 0);
        step();
        chk("ab_m1_busy", bus.busy, 1);
        chk("ab_m1_owner", bus.owner, 1);
        chk("ab_m1_addr", bus.oreq.addr, 32'h3100_0000);

        // Reset during beat 3 of master 1
        do_reset();
        set_req(1, mk_req(1'b1, 1'b0, 32'h4000_0000, MLEN8));
        step();
        for (int k = 0; k < 2; k++) begin
            bus.oresp = mk_resp(1'b1, 1'b0, 64'(k));
            step();
        end
        bus.oresp = mk_resp(1'b1, 1'b0, 64'h3);
        reset = 1'b1;
        step();
        chk("rb_valid", bus.oreq.valid, 0);
        chk("rb_busy", bus.busy, 0);
        chk("rb_owner", bus.owner, 0);
        for (int i = 0; i < N; i++) chk("rb_iresp", resp_at(i), '0);
        reset     = 1'b0;
        bus.oresp = '0;
        step();
        chk("rb_regrant_busy", bus.busy, 1);
        chk("rb_regrant_owner", bus.owner, 1);

        // Continuous contention, single-beat transactions
        do_reset();
        set_req(0, mk_req(1'b1, 1'b0, 32'h5000_0000, MLEN1));
        set_req(1, mk_req(1'b1, 1'b0, 32'h5100_0000, MLEN1));
        bus.oresp = mk_resp(1'b1, 1'b1, 64'h55);
        for (int c = 0; c < 8; c++) begin
            #1;
            chk("cont_busy", bus.busy, c % 2);
            if (c % 2 == 1)
                chk("cont_owner", bus.owner, RR ? (c / 2) % 2 : 0);
            step();
        end

        // Randomized traffic against the model
        do_reset();
        m_busy = 1'b0;
        m_own  = 0;
        m_prio = 0;
        for (int cyc = 0; cyc < 1500; cyc++) begin
            reset = ($urandom_range(0, 99) == 0);
            for (int i = 0; i < N; i++) begin
                r          = mk_req($urandom_range(0, 9) < 6, 1'($urandom), $urandom,
                                    4'($urandom_range(0, 15)));
                r.data     = {$urandom, $urandom};
                r.strobe   = 8'($urandom);
                set_req(i, r);
            end
            bus.oresp = mk_resp(1'($urandom), $urandom_range(0, 3) == 0, {$urandom, $urandom});
            #1;
            chk("rnd_busy", bus.busy, m_busy);
            chk("rnd_owner", bus.owner, m_own);
            chk("rnd_oreq", bus.oreq, m_busy ? req_at(m_own) : '0);
            for (int i = 0; i < N; i++)
                chk("rnd_iresp", resp_at(i), (m_busy && i == m_own) ? bus.oresp : '0);
            // advance model across the coming edge
            for (int i = 0; i < N; i++) vv[i] = req_at(i).valid;
            if (reset) begin
                m_busy = 1'b0;
                m_own  = 0;
                m_prio = 0;
            end else if (!m_busy) begin
                w = pick(vv, RR ? m_prio : 0);
                if (w >= 0) begin
                    m_busy = 1'b1;
                    m_own  = w;
                end
            end else if ((bus.oresp.ready && bus.oresp.last) || !vv[m_own]) begin
                m_busy = 1'b0;
                m_prio = (m_own + 1) % N;
            end
            step();
        end
        reset = 1'b0;

        $display("%0d/%0d checks passed", n_tot - n_fail, n_tot);
        $finish;
    end

endmodule
